ecc_scrub_ctrl: RTL and testbench
=================================

Name: ecc_scrub_ctrl

Overview:
Background memory scrubber that sequences the SECDED decode/encode datapath (64-bit data, 8-bit ECC).
- Walks a memory address range and reads each word.
- Drives the word through an external ecc_dec instance (2-cycle latency, err_sts 00/01/10/11).
- On a correctable error, re-encodes the data through an external ecc_enc instance and writes the word back.
- Counts corrected and uncorrectable events and reports each error address.

Parameters:
ADDR_WIDTH, 10, memory word address width
DEC_LATENCY, 2, cycles from stable dec input to valid decoder output
ENC_LATENCY, 1, cycles from stable enc input to valid enc_ecc_out
CNT_WIDTH, 16, error counter width

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
scrub_en  in  1  enable scrubbing
interval  in  16  idle cycles between word reads
addr_last  in  ADDR_WIDTH  last address of range (range is 0..addr_last)
clr_cnt  in  1  synchronous clear of both counters
mem_req  out  1  memory request
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  64  write data
mem_wecc  out  8  write ECC
mem_ack  in  1  request accepted; read data valid in the same cycle
mem_rdata  in  64  read data
mem_recc  in  8  read ECC
dec_data_in  out  64  to ecc_dec data_in
dec_ecc_in  out  8  to ecc_dec ecc_in
dec_data_out  in  64  from ecc_dec data_out
dec_err_sts  in  2  from ecc_dec err_sts_out
enc_data_in  out  64  to ecc_enc data_in
enc_ecc_out  in  8  from ecc_enc ecc_out
busy  out  1  FSM not in IDLE
err_valid  out  1  one-cycle pulse, err_addr/err_sts valid
err_addr  out  ADDR_WIDTH  address of the error word
err_sts  out  2  decoder status of the error word
corr_cnt  out  CNT_WIDTH  count of status 01 and 10 events
uncorr_cnt  out  CNT_WIDTH  count of status 11 events
pass_done  out  1  one-cycle pulse when addr_last completes

Behaviour:
- Reset (async, rstn low):
  - FSM goes to IDLE; internal address = 0.
  - All outputs are 0, including the dec/enc data registers and both counters.
  - Reset mid-operation abandons any access with no write.
- FSM states and transitions:
  - IDLE -> WAIT when scrub_en = 1.
  - WAIT: counts interval cycles, then -> READ. interval = 0 means WAIT lasts 1 cycle.
  - READ: mem_req = 1, mem_we = 0, mem_addr = current address, all held until mem_ack.
    - On the ack cycle, mem_rdata/mem_recc are registered into dec_data_in/dec_ecc_in.
    - Then -> DEC.
  - DEC: dec inputs held stable for DEC_LATENCY+1 cycles (default 3).
    - dec_err_sts and dec_data_out are sampled in the last DEC cycle.
    - Action by sampled status:
      - 00: -> NEXT.
      - 01 or 10: register dec_data_out into enc_data_in; corr_cnt += 1; err_valid pulse; -> ENC.
      - 11: uncorr_cnt += 1; err_valid pulse; no write; -> NEXT.
  - ENC: lasts ENC_LATENCY+1 cycles.
    - enc_ecc_out is captured into mem_wecc in the last cycle.
    - mem_wdata = enc_data_in.
    - Then -> WRITE.
  - WRITE: mem_req = 1, mem_we = 1; address, wdata and wecc held until mem_ack, then -> NEXT.
  - NEXT:
    - If address == addr_last: address -> 0 and pass_done pulses. Otherwise address += 1.
    - Then -> WAIT if scrub_en = 1, else -> IDLE.
- Handshake: mem_req never drops before mem_ack. mem_req deasserts the cycle after ack; there are no back-to-back requests.
- scrub_en deasserted mid-word: the current word completes, including any pending write-back, then the FSM enters IDLE. The address is retained; re-enable resumes at the next address.
- scrub_en deasserted in WAIT: -> IDLE immediately.
- Counters: saturate at all ones.
  - clr_cnt has priority: if clr_cnt and an increment occur in the same cycle, the result is 0.
- err_valid is asserted in the cycle after the DEC sample. err_addr and err_sts hold until the next err_valid.
- addr_last and interval are sampled only at NEXT and on WAIT entry. Changing them mid-word has no effect on the current word.
- If the current address > addr_last after addr_last is reduced, NEXT wraps to 0.

Test Plan:
- Clean memory, addr_last = 3, interval = 0, ack in the same cycle as req -> 4 reads, 0 writes, pass_done pulses once after address 3, both counters stay 0.
- Word 2 has data bit 5 flipped (status 01) -> write to address 2 with the original data and the re-encoded ECC; corr_cnt = 1; err_valid with err_addr = 2, err_sts = 01.
- Word 1 has ECC bit 3 flipped (status 10) -> write with unchanged data and correct ECC; corr_cnt = 1.
- Word 0 has data bits 0 and 1 flipped (status 11) -> no write; uncorr_cnt = 1; err_sts = 11; mem_we never asserted for address 0.
- Fixed-pattern checks:
  - Counter at 0xFFFF plus another 01 event -> counter stays 0xFFFF.
  - clr_cnt in the same cycle as an increment -> counter = 0.
- Controls during operation:
  - scrub_en dropped during the WRITE wait with ack delayed 5 cycles -> write completes, then IDLE with busy = 0.
  - rstn pulsed during DEC -> all outputs 0, no write, restart from address 0.

Source files
------------

// File: rtl/ecc_scrub_ctrl.sv
// Background SECDED memory scrubber: walks 0..addr_last, decodes each word through an
// external ecc_dec, writes back re-encoded data on correctable errors, and counts events.
module ecc_scrub_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned DEC_LATENCY = 2,
  parameter int unsigned ENC_LATENCY = 1,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  scrub_en,
  input  logic [15:0]           interval,
  input  logic [ADDR_WIDTH-1:0] addr_last,
  input  logic                  clr_cnt,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [63:0]           mem_wdata,
  output logic [7:0]            mem_wecc,
  input  logic                  mem_ack,
  input  logic [63:0]           mem_rdata,
  input  logic [7:0]            mem_recc,
  output logic [63:0]           dec_data_in,
  output logic [7:0]            dec_ecc_in,
  input  logic [63:0]           dec_data_out,
  input  logic [1:0]            dec_err_sts,
  output logic [63:0]           enc_data_in,
  input  logic [7:0]            enc_ecc_out,
  output logic                  busy,
  output logic                  err_valid,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [1:0]            err_sts,
  output logic [CNT_WIDTH-1:0]  corr_cnt,
  output logic [CNT_WIDTH-1:0]  uncorr_cnt,
  output logic                  pass_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_READ, S_DEC, S_ENC, S_WRITE, S_NEXT
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [63:0]           dec_data_q, dec_data_d;
  logic [7:0]            dec_ecc_q, dec_ecc_d;
  logic [63:0]           enc_data_q, enc_data_d;
  logic [7:0]            wecc_q, wecc_d;
  logic                  err_valid_q, err_valid_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic [1:0]            err_sts_q, err_sts_d;
  logic [CNT_WIDTH-1:0]  corr_q, corr_d;
  logic [CNT_WIDTH-1:0]  uncorr_q, uncorr_d;
  logic                  pass_q, pass_d;

  logic dec_last, enc_last, rd_ack, corr_inc, uncorr_inc, wrap;

  // One shared timer serves WAIT (down-count) and DEC/ENC (up-count to latency).
  assign dec_last   = (state_q == S_DEC) && (cnt_q == 16'(DEC_LATENCY));
  assign enc_last   = (state_q == S_ENC) && (cnt_q == 16'(ENC_LATENCY));
  assign rd_ack     = (state_q == S_READ) && mem_ack;
  assign corr_inc   = dec_last && ((dec_err_sts == 2'b01) || (dec_err_sts == 2'b10));
  assign uncorr_inc = dec_last && (dec_err_sts == 2'b11);
  assign wrap       = (addr_q >= addr_last);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (scrub_en) begin
          state_d = S_WAIT;
          cnt_d   = interval;
        end
      end
      S_WAIT: begin
        if (!scrub_en)              state_d = S_IDLE;
        else if (cnt_q <= 16'd1)    state_d = S_READ;
        else                        cnt_d   = cnt_q - 16'd1;
      end
      S_READ: begin
        if (mem_ack) begin
          state_d = S_DEC;
          cnt_d   = '0;
        end
      end
      S_DEC: begin
        if (dec_last) begin
          state_d = corr_inc ? S_ENC : S_NEXT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_ENC: begin
        if (enc_last) state_d = S_WRITE;
        else          cnt_d   = cnt_q + 16'd1;
      end
      S_WRITE: begin
        if (mem_ack) state_d = S_NEXT;
      end
      S_NEXT: begin
        if (scrub_en) begin
          state_d = S_WAIT;
          cnt_d   = interval;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    pass_d      = 1'b0;
    if (state_q == S_NEXT) begin
      // >= also covers addr_last having been lowered below the current address.
      addr_d = wrap ? '0 : addr_q + ADDR_WIDTH'(1);
      pass_d = wrap;
    end
    dec_data_d  = rd_ack ? mem_rdata : dec_data_q;
    dec_ecc_d   = rd_ack ? mem_recc  : dec_ecc_q;
    enc_data_d  = corr_inc ? dec_data_out : enc_data_q;
    wecc_d      = enc_last ? enc_ecc_out  : wecc_q;
    err_valid_d = corr_inc || uncorr_inc;
    err_addr_d  = err_valid_d ? addr_q      : err_addr_q;
    err_sts_d   = err_valid_d ? dec_err_sts : err_sts_q;
    if (clr_cnt)                      corr_d = '0;
    else if (corr_inc && corr_q != '1) corr_d = corr_q + CNT_WIDTH'(1);
    else                              corr_d = corr_q;
    if (clr_cnt)                          uncorr_d = '0;
    else if (uncorr_inc && uncorr_q != '1) uncorr_d = uncorr_q + CNT_WIDTH'(1);
    else                                  uncorr_d = uncorr_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q      <= '0;
      dec_data_q  <= '0;
      dec_ecc_q   <= '0;
      enc_data_q  <= '0;
      wecc_q      <= '0;
      err_valid_q <= 1'b0;
      err_addr_q  <= '0;
      err_sts_q   <= '0;
      corr_q      <= '0;
      uncorr_q    <= '0;
      pass_q      <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      dec_data_q  <= dec_data_d;
      dec_ecc_q   <= dec_ecc_d;
      enc_data_q  <= enc_data_d;
      wecc_q      <= wecc_d;
      err_valid_q <= err_valid_d;
      err_addr_q  <= err_addr_d;
      err_sts_q   <= err_sts_d;
      corr_q      <= corr_d;
      uncorr_q    <= uncorr_d;
      pass_q      <= pass_d;
    end
  end

  always_comb begin
    mem_req     = (state_q == S_READ) || (state_q == S_WRITE);
    mem_we      = (state_q == S_WRITE);
    busy        = (state_q != S_IDLE);
    mem_addr    = addr_q;
    mem_wdata   = enc_data_q;
    mem_wecc    = wecc_q;
    dec_data_in = dec_data_q;
    dec_ecc_in  = dec_ecc_q;
    enc_data_in = enc_data_q;
    err_valid   = err_valid_q;
    err_addr    = err_addr_q;
    err_sts     = err_sts_q;
    corr_cnt    = corr_q;
    uncorr_cnt  = uncorr_q;
    pass_done   = pass_q;
  end

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Directed bench for ecc_scrub_ctrl with a behavioural memory, a 72/64 Hamming SECDED
// encoder/decoder standing in for ecc_enc/ecc_dec, and narrow counters to reach saturation.
module tb_ecc_scrub_ctrl;
  localparam int unsigned AW = 10;
  localparam int unsigned CW = 4;
  localparam logic [63:0] DAT [4] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                      64'hA5A5_5A5A_DEAD_BEEF, 64'h0F0F_F0F0_1357_9BDF};

  logic clk = 1'b0, rstn = 1'b0, scrub_en = 1'b0, clr_cnt = 1'b0;
  logic [15:0] interval = '0;
  logic [AW-1:0] addr_last = '0;
  logic mem_req, mem_we, busy, err_valid, pass_done;
  logic [AW-1:0] mem_addr, err_addr;
  logic [63:0] mem_wdata, dec_data_in, enc_data_in;
  logic [7:0] mem_wecc, dec_ecc_in;
  logic [1:0] err_sts;
  logic [CW-1:0] corr_cnt, uncorr_cnt;
  logic mem_ack = 1'b0;
  logic [63:0] mem_rdata = '0, dec_data_out = '0;
  logic [7:0] mem_recc = '0, enc_ecc_out = '0;
  logic [1:0] dec_err_sts = '0;
  logic [65:0] dec_s1 = '0;

  int unsigned n_vec = 0, n_err = 0;

  ecc_scrub_ctrl #(.ADDR_WIDTH(AW), .DEC_LATENCY(2), .ENC_LATENCY(1), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn), .scrub_en(scrub_en), .interval(interval), .addr_last(addr_last),
    .clr_cnt(clr_cnt), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wecc(mem_wecc), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .mem_recc(mem_recc), .dec_data_in(dec_data_in), .dec_ecc_in(dec_ecc_in),
    .dec_data_out(dec_data_out), .dec_err_sts(dec_err_sts), .enc_data_in(enc_data_in),
    .enc_ecc_out(enc_ecc_out), .busy(busy), .err_valid(err_valid), .err_addr(err_addr),
    .err_sts(err_sts), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt), .pass_done(pass_done)
  );

  always #5 clk = ~clk;

  // Codeword position of data bit i: positions 3..71 skipping powers of two.
  function automatic logic [6:0] dpos(input int unsigned i);
    int unsigned n;
    n = 0;
    for (int unsigned p = 3; p < 72; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (n == i) return p[6:0];
        n++;
      end
    end
    return 7'd0;
  endfunction

  function automatic logic [7:0] enc_f(input logic [63:0] d);
    logic [6:0] s;
    s = '0;
    for (int unsigned i = 0; i < 64; i++) if (d[i]) s = s ^ dpos(i);
    return {^{d, s}, s};
  endfunction

  function automatic logic [65:0] dec_f(input logic [63:0] d, input logic [7:0] e);
    logic [7:0] c;
    logic [6:0] s;
    logic p;
    logic [63:0] od;
    c = enc_f(d);
    s = e[6:0] ^ c[6:0];
    p = ^{d, e};
    od = d;
    if (s == 7'd0 && !p) return {2'b00, d};
    if (!p) return {2'b11, d};
    if ((s & (s - 7'd1)) == 7'd0) return {2'b10, d};
    for (int unsigned i = 0; i < 64; i++) begin
      if (dpos(i) == s) begin
        od[i] = ~od[i];
        return {2'b01, od};
      end
    end
    return {2'b11, d};
  endfunction

  // Decoder: two-stage pipeline; encoder: one register stage.
  always @(posedge clk) begin
    dec_s1 <= dec_f(dec_data_in, dec_ecc_in);
    {dec_err_sts, dec_data_out} <= dec_s1;
    enc_ecc_out <= enc_f(enc_data_in);
  end

  logic [63:0] mem_d [4];
  logic [7:0] mem_e [4];
  int unsigned ack_dly = 0, wcnt = 0, n_reads = 0, n_writes = 0, n_drop = 0;
  int unsigned n_errev = 0, n_pass = 0;
  bit sticky = 1'b0, prev_req = 1'b0, prev_ack = 1'b0, we0_seen = 1'b0;
  logic [AW-1:0] last_rd_addr = '0, last_wr_addr = '0;
  logic [63:0] last_wr_data = '0;
  logic [7:0] last_wr_ecc = '0;

  always @(posedge clk) begin
    #1;
    if (prev_req && !prev_ack && !mem_req && rstn) n_drop++;
    mem_ack = 1'b0;
    if (mem_req) begin
      if (wcnt >= ack_dly) begin
        mem_ack = 1'b1;
        wcnt = 0;
        if (mem_we) begin
          n_writes++;
          last_wr_addr = mem_addr;
          last_wr_data = mem_wdata;
          last_wr_ecc  = mem_wecc;
          if (!sticky) begin
            mem_d[mem_addr[1:0]] = mem_wdata;
            mem_e[mem_addr[1:0]] = mem_wecc;
          end
        end else begin
          n_reads++;
          last_rd_addr = mem_addr;
          mem_rdata = mem_d[mem_addr[1:0]];
          mem_recc  = mem_e[mem_addr[1:0]];
        end
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
    prev_req = mem_req;
    prev_ack = mem_ack;
  end

  always @(negedge clk) begin
    if (err_valid) n_errev++;
    if (pass_done) n_pass++;
    if (mem_req && mem_we && mem_addr == '0) we0_seen = 1'b1;
  end

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; scrub_en = 1'b0; clr_cnt = 1'b0; ack_dly = 0; sticky = 1'b0;
    interval = '0;
    @(negedge clk);
    n_reads = 0; n_writes = 0; n_errev = 0; n_pass = 0; we0_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_d[i] = DAT[i];
      mem_e[i] = enc_f(DAT[i]);
    end
    rstn = 1'b1;
  endtask

  task automatic wait_passes(input int n, output bit ok);
    int seen;
    seen = 0;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (pass_done) begin
        seen++;
        if (seen == n) begin
          scrub_en = 1'b0;
          ok = 1'b1;
          break;
        end
      end
    end
    scrub_en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_rd_ack(input logic [AW-1:0] a, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (mem_req && !mem_we && mem_ack && mem_addr == a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++; if ({busy, mem_req, mem_we, err_valid, pass_done} !== 5'b0) begin n_err++;
      $display("FAIL reset_ctrl got %b want 00000", {busy, mem_req, mem_we, err_valid, pass_done}); end
    n_vec++; if ({corr_cnt, uncorr_cnt} !== '0) begin n_err++;
      $display("FAIL reset_cnt got %h/%h want 0/0", corr_cnt, uncorr_cnt); end
    n_vec++; if ({mem_addr, dec_data_in, dec_ecc_in, enc_data_in, mem_wecc} !== '0) begin n_err++;
      $display("FAIL reset_regs addr %h dec %h/%h enc %h wecc %h want all 0",
               mem_addr, dec_data_in, dec_ecc_in, enc_data_in, mem_wecc); end
    do_reset();
  endtask

  task automatic test_clean();
    bit ok;
    do_reset();
    addr_last = AW'(3);
    scrub_en = 1'b1;
    wait_passes(1, ok);
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL clean_timeout got %b want 1", ok); end
    n_vec++; if (n_reads !== 4 || n_writes !== 0) begin n_err++;
      $display("FAIL clean_rw reads %0d writes %0d want 4/0", n_reads, n_writes); end
    n_vec++; if (n_pass !== 1 || last_rd_addr !== AW'(3)) begin n_err++;
      $display("FAIL clean_pass pass %0d last %0d want 1/3", n_pass, last_rd_addr); end
    n_vec++; if ({corr_cnt, uncorr_cnt} !== '0 || n_errev !== 0 || busy !== 1'b0) begin n_err++;
      $display("FAIL clean_cnt corr %0d uncorr %0d ev %0d busy %b want 0 0 0 0",
               corr_cnt, uncorr_cnt, n_errev, busy); end
  endtask

  task automatic test_corr_data();
    bit ok;
    do_reset();
    mem_d[2] = DAT[2] ^ 64'h20;
    addr_last = AW'(3);
    scrub_en = 1'b1;
    wait_passes(1, ok);
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL cdata_timeout got %b want 1", ok); end
    n_vec++; if (n_writes !== 1 || last_wr_addr !== AW'(2)) begin n_err++;
      $display("FAIL cdata_wr writes %0d addr %0d want 1/2", n_writes, last_wr_addr); end
    n_vec++; if (last_wr_data !== DAT[2] || last_wr_ecc !== enc_f(DAT[2])) begin n_err++;
      $display("FAIL cdata_word got %h/%h want %h/%h", last_wr_data, last_wr_ecc, DAT[2], enc_f(DAT[2])); end
    n_vec++; if (corr_cnt !== CW'(1) || uncorr_cnt !== '0 || n_errev !== 1) begin n_err++;
      $display("FAIL cdata_cnt corr %0d uncorr %0d ev %0d want 1 0 1", corr_cnt, uncorr_cnt, n_errev); end
    n_vec++; if (err_addr !== AW'(2) || err_sts !== 2'b01) begin n_err++;
      $display("FAIL cdata_err addr %0d sts %b want 2/01", err_addr, err_sts); end
  endtask

  task automatic test_corr_ecc();
    bit ok;
    do_reset();
    mem_e[1] = enc_f(DAT[1]) ^ 8'h08;
    addr_last = AW'(3);
    scrub_en = 1'b1;
    wait_passes(1, ok);
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL cecc_timeout got %b want 1", ok); end
    n_vec++; if (n_writes !== 1 || last_wr_addr !== AW'(1) || last_wr_data !== DAT[1]
                 || last_wr_ecc !== enc_f(DAT[1])) begin n_err++;
      $display("FAIL cecc_wr n %0d addr %0d data %h ecc %h want 1 1 %h %h",
               n_writes, last_wr_addr, last_wr_data, last_wr_ecc, DAT[1], enc_f(DAT[1])); end
    n_vec++; if (corr_cnt !== CW'(1) || err_sts !== 2'b10 || err_addr !== AW'(1)) begin n_err++;
      $display("FAIL cecc_err corr %0d sts %b addr %0d want 1 10 1", corr_cnt, err_sts, err_addr); end
  endtask

  task automatic test_uncorr();
    bit ok;
    do_reset();
    mem_d[0] = DAT[0] ^ 64'h3;
    addr_last = AW'(3);
    scrub_en = 1'b1;
    wait_passes(1, ok);
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL unc_timeout got %b want 1", ok); end
    n_vec++; if (n_writes !== 0 || we0_seen !== 1'b0 || n_reads !== 4) begin n_err++;
      $display("FAIL unc_wr writes %0d we0 %b reads %0d want 0 0 4", n_writes, we0_seen, n_reads); end
    n_vec++; if (uncorr_cnt !== CW'(1) || corr_cnt !== '0) begin n_err++;
      $display("FAIL unc_cnt uncorr %0d corr %0d want 1 0", uncorr_cnt, corr_cnt); end
    n_vec++; if (err_sts !== 2'b11 || err_addr !== AW'(0) || n_errev !== 1) begin n_err++;
      $display("FAIL unc_err sts %b addr %0d ev %0d want 11 0 1", err_sts, err_addr, n_errev); end
  endtask

  task automatic test_saturate_clear();
    bit ok;
    do_reset();
    sticky = 1'b1;
    mem_d[0] = DAT[0] ^ 64'h20;
    addr_last = AW'(0);
    scrub_en = 1'b1;
    wait_passes(14, ok);
    n_vec++; if (ok !== 1'b1 || corr_cnt !== CW'(14)) begin n_err++;
      $display("FAIL sat_14 ok %b corr %0d want 1/14", ok, corr_cnt); end
    scrub_en = 1'b1;
    wait_passes(1, ok);
    n_vec++; if (ok !== 1'b1 || corr_cnt !== CW'(15)) begin n_err++;
      $display("FAIL sat_15 ok %b corr %0d want 1/15", ok, corr_cnt); end
    scrub_en = 1'b1;
    wait_passes(2, ok);
    n_vec++; if (ok !== 1'b1 || corr_cnt !== CW'(15)) begin n_err++;
      $display("FAIL sat_hold ok %b corr %0d want 1/15", ok, corr_cnt); end
    scrub_en = 1'b1;
    wait_rd_ack(AW'(0), ok);
    repeat (3) @(negedge clk);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    n_vec++; if (ok !== 1'b1 || err_valid !== 1'b1 || corr_cnt !== '0) begin n_err++;
      $display("FAIL clr_collide ok %b ev %b corr %0d want 1 1 0", ok, err_valid, corr_cnt); end
    wait_passes(1, ok);
    n_vec++; if (ok !== 1'b1 || corr_cnt !== '0) begin n_err++;
      $display("FAIL clr_after ok %b corr %0d want 1/0", ok, corr_cnt); end
    scrub_en = 1'b1;
    wait_passes(1, ok);
    n_vec++; if (ok !== 1'b1 || corr_cnt !== CW'(1)) begin n_err++;
      $display("FAIL clr_restart ok %b corr %0d want 1/1", ok, corr_cnt); end
  endtask

  task automatic test_en_drop_write();
    bit ok;
    do_reset();
    ack_dly = 5;
    mem_d[2] = DAT[2] ^ 64'h20;
    addr_last = AW'(3);
    scrub_en = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (mem_req && mem_we) begin ok = 1'b1; break; end
    end
    scrub_en = 1'b0;
    n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL drop_wr_seen got %b want 1", ok); end
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    repeat (3) @(negedge clk);
    n_vec++; if (ok !== 1'b1 || busy !== 1'b0) begin n_err++;
      $display("FAIL drop_idle ok %b busy %b want 1 0", ok, busy); end
    n_vec++; if (n_writes !== 1 || last_wr_addr !== AW'(2) || last_wr_data !== DAT[2]
                 || n_reads !== 3) begin n_err++;
      $display("FAIL drop_wr writes %0d addr %0d data %h reads %0d want 1 2 %h 3",
               n_writes, last_wr_addr, last_wr_data, n_reads, DAT[2]); end
    scrub_en = 1'b1;
    wait_rd_ack(AW'(3), ok);
    n_vec++; if (ok !== 1'b1 || n_reads !== 4) begin n_err++;
      $display("FAIL drop_resume ok %b reads %0d want 1 4", ok, n_reads); end
    wait_passes(1, ok);
    n_vec++; if (ok !== 1'b1 || n_pass !== 1) begin n_err++;
      $display("FAIL drop_pass ok %b pass %0d want 1 1", ok, n_pass); end
  endtask

  task automatic test_reset_in_dec();
    bit ok;
    do_reset();
    mem_d[1] = DAT[1] ^ 64'h20;
    addr_last = AW'(3);
    scrub_en = 1'b1;
    wait_rd_ack(AW'(1), ok);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    n_vec++; if (ok !== 1'b1 || {busy, mem_req, err_valid, pass_done} !== 4'b0) begin n_err++;
      $display("FAIL rdec_ctrl ok %b ctrl %b want 1 0000", ok, {busy, mem_req, err_valid, pass_done}); end
    n_vec++; if ({mem_addr, dec_data_in, dec_ecc_in, enc_data_in, corr_cnt} !== '0) begin n_err++;
      $display("FAIL rdec_regs addr %0d dec %h enc %h corr %0d want 0", mem_addr, dec_data_in,
               enc_data_in, corr_cnt); end
    @(negedge clk);
    rstn = 1'b1;
    n_vec++; if (n_writes !== 0) begin n_err++; $display("FAIL rdec_nowr writes %0d want 0", n_writes); end
    wait_rd_ack(AW'(0), ok);
    n_vec++; if (ok !== 1'b1 || n_reads !== 3) begin n_err++;
      $display("FAIL rdec_restart ok %b reads %0d want 1 3", ok, n_reads); end
    wait_passes(1, ok);
    n_vec++; if (ok !== 1'b1 || n_writes !== 1 || last_wr_addr !== AW'(1) || corr_cnt !== CW'(1))
      begin n_err++;
      $display("FAIL rdec_finish ok %b writes %0d addr %0d corr %0d want 1 1 1 1",
               ok, n_writes, last_wr_addr, corr_cnt); end
    n_vec++; if (n_drop !== 0) begin n_err++; $display("FAIL handshake_drop got %0d want 0", n_drop); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_corr_data();
    test_corr_ecc();
    test_uncorr();
    test_saturate_clear();
    test_en_drop_write();
    test_reset_in_dec();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
